// File: rtl/ssd_scan.sv
// ssd_scan: eight-digit time-multiplexed seven-segment scanner for a common-anode display.
//   ssd_scan_clk   in  1  : clock, rising edge
//   ssd_scan_rst   in  1  : synchronous active-high reset
//   ssd_scan_en    in  1  : scan enable, low blanks and freezes the scan
//   ssd_scan_data  in  32 : eight hex nibbles, digit k = [4k+3:4k], digit 0 rightmost
//   ssd_scan_dp    in  8  : per-digit decimal-point request, active-high
//   ssd_scan_an    out 8  : anodes, active-low, one-hot-low while scanning
//   ssd_scan_seg   out 7  : cathodes {CG,CF,CE,CD,CC,CB,CA}, active-low
//   ssd_scan_dp_n  out 1  : decimal-point cathode, active-low
// Define SSD_SCAN_LZ_BLANK_EN to blank leading-zero digits (digit 0 always lit).
module ssd_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        ssd_scan_clk,
  input  logic        ssd_scan_rst,
  input  logic        ssd_scan_en,
  input  logic [31:0] ssd_scan_data,
  input  logic [7:0]  ssd_scan_dp,
  output logic [7:0]  ssd_scan_an,
  output logic [6:0]  ssd_scan_seg,
  output logic        ssd_scan_dp_n
);
  localparam logic [19:0] LAST = 20'(REFRESH_DIV - 1);
  logic [19:0] div_cnt;
  logic [2:0]  idx;
  logic [31:0] snap_data;
  logic [7:0]  snap_dp;
  logic        load_pend;
  logic        tick, load, blank;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  assign tick = div_cnt == LAST;
  // a fresh frame snapshot is taken on the edge that enters digit 0, or once after reset
  assign load = load_pend | (tick && idx == 3'd7);
  assign nib  = snap_data[{idx, 2'b00} +: 4];
  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end
`ifdef SSD_SCAN_LZ_BLANK_EN
  // blank when this digit and every more-significant digit is zero and no DP is requested
  assign blank = idx != 3'd0 && (snap_data >> {idx, 2'b00}) == 32'd0 && !snap_dp[idx];
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge ssd_scan_clk) begin
    if (ssd_scan_rst) begin
      div_cnt       <= '0;
      idx           <= '0;
      snap_data     <= '0;
      snap_dp       <= '0;
      load_pend     <= 1'b1;
      ssd_scan_an   <= 8'hFF;
      ssd_scan_seg  <= 7'h7F;
      ssd_scan_dp_n <= 1'b1;
    end else if (ssd_scan_en) begin
      div_cnt <= tick ? '0 : div_cnt + 20'd1;
      if (tick) idx <= idx + 3'd1;
      if (load) begin
        snap_data <= ssd_scan_data;
        snap_dp   <= ssd_scan_dp;
        load_pend <= 1'b0;
      end
      ssd_scan_an   <= blank ? 8'hFF : ~(8'd1 << idx);
      ssd_scan_seg  <= blank ? 7'h7F : glyph;
      ssd_scan_dp_n <= blank | ~snap_dp[idx];
    end else begin
      ssd_scan_an   <= 8'hFF;
      ssd_scan_seg  <= 7'h7F;
      ssd_scan_dp_n <= 1'b1;
    end
  end
endmodule

// File: doc/ssd_scan.md
# ssd_scan

- Eight-digit, time-multiplexed seven-segment display scanner for the board's common-anode display.
- Sits directly downstream of the up-counter stage: takes counter nibbles (the 4-bit counter output in the low nibble), decodes each to hex glyphs and drives anodes, cathodes and DP.
- Snapshots the whole data bus once per scan frame, so a counter changing mid-frame never tears the display.

## Interface

Parameters:
- `REFRESH_DIV`, 100000: clocks per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.

Ports:
- `ssd_scan_clk` in 1: the single clock; all state updates on its rising edge.
- `ssd_scan_rst` in 1: reset, synchronous, active-high.
- `ssd_scan_en` in 1: scan enable; low blanks the display and freezes the scan.
- `ssd_scan_data` in 32: eight hex nibbles; digit k is `[4k+3:4k]`, digit 0 rightmost.
- `ssd_scan_dp` in 8: decimal-point request per digit, active-high.
- `ssd_scan_an` out 8: anodes, active-low, one-hot-low while scanning.
- `ssd_scan_seg` out 7: cathodes `{CG,CF,CE,CD,CC,CB,CA}`, active-low.
- `ssd_scan_dp_n` out 1: decimal-point cathode, active-low.

## Operation

- State:
  - `div_cnt`: 20-bit divider.
  - `idx`: 3-bit digit index.
  - `snap_data` / `snap_dp`: 32-bit / 8-bit frame snapshot.
  - `load_pend`: snapshot-load flag.
- Reset (synchronous): `div_cnt`=0, `idx`=0, snapshots=0, `load_pend`=1.
  - Outputs: `an`=8'hFF, `seg`=7'h7F, `dp_n`=1.
- Enabled cycle, `div_cnt` < `REFRESH_DIV`-1: `div_cnt` increments.
- Enabled cycle, `div_cnt` == `REFRESH_DIV`-1 (tick): `div_cnt`←0 and `idx`←`idx`+1, wrapping 7→0.
- Snapshot load occurs on:
  - the first enabled cycle with `load_pend`=1, after which `load_pend` clears; or
  - a tick where `idx`==7, i.e. entering digit 0.
  - The snapshot is otherwise stable for the whole frame.
- Decode, hex 0–F, active-low. Examples: 0→7'h40, 1→7'h79, 3→7'h30, 8→7'h00, A→7'h08, F→7'h0E.
- Output registers (every enabled cycle):
  - `an`←~(1<<`idx`).
  - `seg`←decode(`snap_data` digit `idx`).
  - `dp_n`←~`snap_dp[idx]`.
- Disabled (`en`=0):
  - `div_cnt`, `idx`, snapshots and `load_pend` hold.
  - Next cycle outputs are `an`=8'hFF, `seg`=7'h7F, `dp_n`=1.
  - Re-enable resumes from the held `div_cnt`/`idx` with no restart.
- Reset mid-frame overrides everything. Outputs are blank the cycle after reset is sampled, and a fresh snapshot is taken on the first enabled cycle after release.
- Width rules:
  - `div_cnt` compares against `REFRESH_DIV`-1 only; it never exceeds it.
  - `idx` wraps naturally in 3 bits.

## Timing

- Output latency: one clock from (`idx`, snapshot) to `an`/`seg`/`dp_n`.
  - A tick at edge N changes `idx` at N, and the anode moves at N+1.
- Digit slot: `REFRESH_DIV` clocks. Full frame: 8×`REFRESH_DIV` clocks.
- First enabled cycle after reset: the snapshot loads at edge 1, and outputs show digit 0 of that snapshot at edge 2.
- Data changes are visible at the next digit-0 slot, at worst one frame later.
- Simultaneous tick and `en` falling: `en`=0 wins, and nothing advances.

## Configuration

- `SSD_SCAN_LZ_BLANK_EN`: leading-zero blanking.
- Defined:
  - Digit k>0 is blanked (`an` all high and `seg`=7'h7F for that slot, `dp_n`=1) when `snap_data` digits k..7 are all zero and `snap_dp[k]`=0.
  - Digit 0 is never blanked. Slot timing is unchanged.
- Undefined: all eight digits are always driven, including leading zeros.

## Test plan

All scenarios use `REFRESH_DIV`=4.

1. Reset: `rst`=1 for 3 cycles → `an`=8'hFF, `seg`=7'h7F, `dp_n`=1; release with `en`=1 → after 2 cycles `an`=8'hFE, `seg` = decode of digit 0.
2. Scan order: data=32'h76543210, `en`=1 → `an` steps FE, FD, FB, … 7F, FE every 4 clocks; `seg` is 40, 79, … in order; 8 slots per 32-clock frame.
3. Tearing: change data to 32'hFFFFFFFF while `idx`=3 → digits 4–7 still show old values; from the next digit-0 slot all show 7'h0E.
4. Enable hold: drop `en` for 10 cycles mid-slot → `an`=8'hFF throughout; on re-enable the same digit resumes with the remaining slot count preserved.
5. DP and mid-frame reset: `dp`=8'h05 → `dp_n`=0 only on digits 0 and 2; assert `rst` during digit 5 → blank next cycle, restart at digit 0.
6. With `SSD_SCAN_LZ_BLANK_EN`, data=32'h00000030 → digits 2–7 blank, digit 1 shows 7'h30, digit 0 shows 7'h40. Without the macro, all digits are lit.
